// File: rtl/stepper_pkg.sv
// ============================================================================
// Module   : stepper_pkg
// Purpose  : Shared types, default timing constants and period clamp helper
//            for the stepper motion controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package stepper_pkg;

    typedef enum logic [1:0] {
        AX_IDLE  = 2'd0,
        AX_SETUP = 2'd1,
        AX_RUN   = 2'd2,
        AX_JOG   = 2'd3
    } axis_state_e;

    localparam int DEF_PULSE_W    = 16;
    localparam int DEF_DIR_SETUP  = 8;
    localparam int DEF_JOG_PERIOD = 100000;

    // A period shorter than one full high+low pulse would merge STEP pulses.
    function automatic logic [63:0] clamp_period(input logic [63:0] period,
                                                 input logic [63:0] min_period);
        return (period < min_period) ? min_period : period;
    endfunction

endpackage

`default_nettype wire

// File: rtl/stepper_axis.sv
// ============================================================================
// Module   : stepper_axis
// Purpose  : One stepper axis: command/jog FSM, STEP pulse timing, DIR
//            setup delay and signed position tracking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stepper_axis
    import stepper_pkg::*;
#(
    parameter int STEP_W     = 24,
    parameter int CNT_W      = 32,
    parameter int POS_W      = 32,
    parameter int PULSE_W    = DEF_PULSE_W,
    parameter int DIR_SETUP  = DEF_DIR_SETUP,
    parameter int JOG_PERIOD = DEF_JOG_PERIOD
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              accept,
    input  logic              cmd_dir,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic [CNT_W-1:0]  cmd_period,
    input  logic              abort,
    input  logic              jog_en,
    input  logic              jog_dir,
    output logic              idle,
    output logic              step_out,
    output logic              dir_out,
    output logic              busy,
    output logic              done,
    output logic [POS_W-1:0]  position
);

    localparam logic [CNT_W-1:0] C_MIN_PERIOD = CNT_W'(2 * PULSE_W);
    localparam logic [CNT_W-1:0] C_JOG_PERIOD =
        CNT_W'(clamp_period(64'(JOG_PERIOD), 64'(2 * PULSE_W)));
    localparam logic [CNT_W-1:0] C_SETUP_LOAD = CNT_W'(DIR_SETUP - 1);
    localparam logic [CNT_W-1:0] C_PULSE_LOAD = CNT_W'(PULSE_W - 1);

    axis_state_e       state_q, state_d;
    logic [CNT_W-1:0]  per_q, per_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [CNT_W-1:0]  pulse_q, pulse_d;
    logic [STEP_W-1:0] rem_q, rem_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic              step_q, step_d;
    logic              dir_q, dir_d;
    logic              done_q, done_d;
    logic              w_rise;
    logic [CNT_W-1:0]  w_period_eff;

    assign w_period_eff = CNT_W'(clamp_period(64'(cmd_period), 64'(C_MIN_PERIOD)));

    always_comb begin
        state_d  = state_q;
        per_d    = per_q;
        period_d = period_q;
        pulse_d  = pulse_q;
        rem_d    = rem_q;
        pos_d    = pos_q;
        step_d   = step_q;
        dir_d    = dir_q;
        done_d   = 1'b0;
        w_rise   = 1'b0;

        if (step_q) begin
            if (pulse_q == '0) begin
                step_d = 1'b0;
            end else begin
                pulse_d = pulse_q - CNT_W'(1);
            end
        end

        // per_q doubles as the DIR setup countdown and the inter-step countdown.
        case (state_q)
            AX_IDLE: begin
                if (accept) begin
                    if (cmd_steps == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = AX_SETUP;
                        dir_d    = cmd_dir;
                        rem_d    = cmd_steps;
                        period_d = w_period_eff;
                        per_d    = C_SETUP_LOAD;
                    end
                end else if (jog_en && !abort) begin
                    state_d  = AX_JOG;
                    dir_d    = jog_dir;
                    period_d = C_JOG_PERIOD;
                    per_d    = C_SETUP_LOAD;
                end
            end
            AX_SETUP: begin
                if (per_q == '0) begin
                    state_d = AX_RUN;
                    w_rise  = 1'b1;
                end else begin
                    per_d = per_q - CNT_W'(1);
                end
            end
            AX_RUN: begin
                if (per_q == '0) begin
                    if (rem_q == '0) begin
                        done_d  = 1'b1;
                        state_d = AX_IDLE;
                    end else begin
                        w_rise = 1'b1;
                    end
                end else begin
                    per_d = per_q - CNT_W'(1);
                end
            end
            AX_JOG: begin
                // Leaving only while STEP is low keeps the last jog pulse whole.
                if (!jog_en && !step_q) begin
                    state_d = AX_IDLE;
                end else if (per_q == '0) begin
                    w_rise = 1'b1;
                end else begin
                    per_d = per_q - CNT_W'(1);
                end
            end
            default: state_d = AX_IDLE;
        endcase

        if (w_rise) begin
            step_d  = 1'b1;
            pulse_d = C_PULSE_LOAD;
            per_d   = period_q - CNT_W'(1);
            rem_d   = rem_q - STEP_W'(1);
            pos_d   = dir_q ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));
        end

        if (abort && (state_q != AX_IDLE)) begin
            state_d = AX_IDLE;
            step_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= AX_IDLE;
            per_q    <= '0;
            period_q <= '0;
            pulse_q  <= '0;
            rem_q    <= '0;
            pos_q    <= '0;
            step_q   <= 1'b0;
            dir_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            per_q    <= per_d;
            period_q <= period_d;
            pulse_q  <= pulse_d;
            rem_q    <= rem_d;
            pos_q    <= pos_d;
            step_q   <= step_d;
            dir_q    <= dir_d;
            done_q   <= done_d;
        end
    end

    assign idle     = (state_q == AX_IDLE);
    assign busy     = (state_q != AX_IDLE);
    assign step_out = step_q;
    assign dir_out  = dir_q;
    assign done     = done_q;
    assign position = pos_q;

endmodule

`default_nettype wire

// File: rtl/stepper_motion_ctrl.sv
// ============================================================================
// Module   : stepper_motion_ctrl
// Purpose  : Multi-axis stepper pulse generator; decodes the shared command
//            port into per-axis accept strobes and replicates stepper_axis.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stepper_motion_ctrl
    import stepper_pkg::*;
#(
    parameter  int N_AXES     = 2,
    parameter  int STEP_W     = 24,
    parameter  int CNT_W      = 32,
    parameter  int POS_W      = 32,
    parameter  int PULSE_W    = DEF_PULSE_W,
    parameter  int DIR_SETUP  = DEF_DIR_SETUP,
    parameter  int JOG_PERIOD = DEF_JOG_PERIOD,
    localparam int AXIS_W     = (N_AXES > 1) ? $clog2(N_AXES) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [AXIS_W-1:0]       cmd_axis,
    input  logic                    cmd_dir,
    input  logic [STEP_W-1:0]       cmd_steps,
    input  logic [CNT_W-1:0]        cmd_period,
    input  logic                    abort,
    input  logic [N_AXES-1:0]       jog_en,
    input  logic [N_AXES-1:0]       jog_dir,
    output logic [N_AXES-1:0]       step_out,
    output logic [N_AXES-1:0]       dir_out,
    output logic [N_AXES-1:0]       busy,
    output logic [N_AXES-1:0]       done,
    output logic [N_AXES*POS_W-1:0] position
);

    logic [N_AXES-1:0] axis_idle;

    // Axis codes beyond N_AXES match no entry and therefore never read ready.
    always_comb begin
        cmd_ready = 1'b0;
        for (int i = 0; i < N_AXES; i++) begin
            if (cmd_axis == AXIS_W'(i)) begin
                cmd_ready = axis_idle[i] && !abort;
            end
        end
    end

    for (genvar i = 0; i < N_AXES; i++) begin : g_axis
        logic w_accept;

        assign w_accept = cmd_valid && cmd_ready && (cmd_axis == AXIS_W'(i));

        stepper_axis #(
            .STEP_W     (STEP_W),
            .CNT_W      (CNT_W),
            .POS_W      (POS_W),
            .PULSE_W    (PULSE_W),
            .DIR_SETUP  (DIR_SETUP),
            .JOG_PERIOD (JOG_PERIOD)
        ) u_axis (
            .clock      (clock),
            .reset      (reset),
            .accept     (w_accept),
            .cmd_dir    (cmd_dir),
            .cmd_steps  (cmd_steps),
            .cmd_period (cmd_period),
            .abort      (abort),
            .jog_en     (jog_en[i]),
            .jog_dir    (jog_dir[i]),
            .idle       (axis_idle[i]),
            .step_out   (step_out[i]),
            .dir_out    (dir_out[i]),
            .busy       (busy[i]),
            .done       (done[i]),
            .position   (position[i*POS_W +: POS_W])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_stepper_motion_ctrl.sv
// ============================================================================
// Module   : tb_stepper_motion_ctrl
// Purpose  : Scoreboard bench for stepper_motion_ctrl with a timeline model
//            of STEP rises, done pulses and positions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stepper_motion_ctrl;

    localparam int N      = 2;
    localparam int STEP_W = 24;
    localparam int CNT_W  = 32;
    localparam int POS_W  = 32;
    localparam int PW     = 2;
    localparam int DS     = 4;
    localparam int JP     = 6;
    localparam int NEVER  = 32'h3fff_ffff;

    typedef struct {
        int at;
        int pos;
    } rise_t;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic                cmd_valid, cmd_ready, cmd_dir, abort;
    logic [0:0]          cmd_axis;
    logic [STEP_W-1:0]   cmd_steps;
    logic [CNT_W-1:0]    cmd_period;
    logic [N-1:0]        jog_en, jog_dir, step_out, dir_out, busy, done;
    logic [N*POS_W-1:0]  position;

    logic [1:0]          cmd_axis3;
    logic                cmd_ready3;
    logic [2:0]          step3, dir3, busy3, done3;
    logic [3*POS_W-1:0]  position3;

    int    cyc = 0;
    int    n_tests = 0;
    int    n_fail = 0;
    rise_t exp_rise[N][$];
    int    exp_done[N][$];
    int    model_pos[N];
    int    free_at[N];
    bit    width_en = 1'b1;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    stepper_motion_ctrl #(
        .N_AXES(N), .STEP_W(STEP_W), .CNT_W(CNT_W), .POS_W(POS_W),
        .PULSE_W(PW), .DIR_SETUP(DS), .JOG_PERIOD(JP)
    ) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_axis(cmd_axis), .cmd_dir(cmd_dir), .cmd_steps(cmd_steps),
        .cmd_period(cmd_period), .abort(abort), .jog_en(jog_en), .jog_dir(jog_dir),
        .step_out(step_out), .dir_out(dir_out), .busy(busy), .done(done),
        .position(position)
    );

    // Three-axis copy: the only way to present an axis code >= N_AXES.
    stepper_motion_ctrl #(
        .N_AXES(3), .STEP_W(STEP_W), .CNT_W(CNT_W), .POS_W(POS_W),
        .PULSE_W(PW), .DIR_SETUP(DS), .JOG_PERIOD(JP)
    ) dut3 (
        .clock(clock), .reset(reset), .cmd_valid(1'b0), .cmd_ready(cmd_ready3),
        .cmd_axis(cmd_axis3), .cmd_dir(1'b0), .cmd_steps('0),
        .cmd_period('0), .abort(1'b0), .jog_en(3'b000), .jog_dir(3'b000),
        .step_out(step3), .dir_out(dir3), .busy(busy3), .done(done3),
        .position(position3)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint pos_of(input int a);
        return longint'($signed(position[a*POS_W +: POS_W]));
    endfunction

    // Timeline of one move accepted at edge t; events at or after cut are lost to abort.
    function automatic void push_move(input int a, input bit d, input int steps,
                                      input int period, input int t, input int cut);
        int p;
        int done_at;
        p = (period < 2 * PW) ? 2 * PW : period;
        done_at = (steps == 0) ? t : t + DS + steps * p;
        for (int k = 0; k < steps; k++) begin
            if (t + DS + k * p < cut) begin
                model_pos[a] += d ? 1 : -1;
                exp_rise[a].push_back('{t + DS + k * p, model_pos[a]});
            end
        end
        if (done_at < cut) exp_done[a].push_back(done_at);
        if (steps != 0) free_at[a] = (done_at < cut) ? done_at : cut;
    endfunction

    // Jog entered at edge e_entry, jog_en low from edge d0 on; returns the exit edge.
    function automatic int jog_model(input int a, input bit d, input int e_entry, input int d0);
        int x;
        bit high;
        x = d0;
        do begin
            high = 1'b0;
            for (int r = e_entry + DS; r < x; r += JP)
                if (x >= r + 1 && x <= r + PW) high = 1'b1;
            if (high) x++;
        end while (high);
        for (int r = e_entry + DS; r < x; r += JP) begin
            model_pos[a] += d ? 1 : -1;
            exp_rise[a].push_back('{r, model_pos[a]});
        end
        free_at[a] = x;
        return x;
    endfunction

    // Called just after a negedge; returns just after the following negedge.
    task automatic issue(input int a, input bit d, input int steps, input int period,
                         input int cut_rel);
        bit exp_rdy;
        cmd_axis   = a[0:0];
        cmd_dir    = d;
        cmd_steps  = steps[STEP_W-1:0];
        cmd_period = period;
        cmd_valid  = 1'b1;
        #1;
        exp_rdy = !abort && (cyc >= free_at[a]);
        check($sformatf("cmd_ready_ax%0d", a), cmd_ready, exp_rdy);
        if (exp_rdy)
            push_move(a, d, steps, period, cyc + 1, (cut_rel == 0) ? NEVER : cyc + 1 + cut_rel);
        @(negedge clock);
        cmd_valid = 1'b0;
        if (exp_rdy && steps > 0) check($sformatf("dir_out_ax%0d", a), dir_out[a], d);
    endtask

    initial begin : monitor
        logic [N-1:0] prev;
        int           rise_at[N];
        rise_t        e;
        int           de;
        prev = '0;
        forever begin
            @(posedge clock);
            #1;
            for (int i = 0; i < N; i++) begin
                if (step_out[i] && !prev[i]) begin
                    rise_at[i] = cyc;
                    if (exp_rise[i].size() > 0) e = exp_rise[i].pop_front();
                    else e = '{-1, 0};
                    check($sformatf("rise_cycle_ax%0d", i), cyc, e.at);
                    check($sformatf("rise_pos_ax%0d", i), pos_of(i), e.pos);
                end
                if (!step_out[i] && prev[i] && width_en)
                    check($sformatf("pulse_width_ax%0d", i), cyc - rise_at[i], PW);
                if (done[i]) begin
                    if (exp_done[i].size() > 0) de = exp_done[i].pop_front();
                    else de = -1;
                    check($sformatf("done_cycle_ax%0d", i), cyc, de);
                end
            end
            prev = step_out;
        end
    end

    initial begin : stimulus
        int e_entry;
        int x;
        cmd_valid = 1'b0; cmd_axis = '0; cmd_dir = 1'b0; cmd_steps = '0; cmd_period = '0;
        abort = 1'b0; jog_en = '0; jog_dir = '0; cmd_axis3 = '0;
        model_pos = '{0, 0};
        free_at   = '{0, 0};
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst_step_out", step_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dir_out", dir_out, 0);
        check("rst_position", position, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        for (int v = 0; v < 4; v++) begin
            cmd_axis3 = v[1:0];
            #1;
            check($sformatf("ready3_axis%0d", v), cmd_ready3, (v < 3) ? 1 : 0);
        end

        issue(0, 1'b1, 3, 10, 0);
        repeat (40) @(negedge clock);
        check("move_pos_ax0", pos_of(0), model_pos[0]);
        check("move_busy_ax0", busy[0], 0);

        // Clamped negative move on axis 1, refused re-issue, concurrent axis 0 move
        issue(1, 1'b0, 2, 1, 0);
        issue(1, 1'b1, 1, 5, 0);
        issue(0, 1'b0, 1, 7, 0);
        check("concurrent_busy", busy, 2'b11);
        repeat (30) @(negedge clock);
        check("clamp_pos_ax1", pos_of(1), model_pos[1]);
        check("clamp_pos_ax0", pos_of(0), model_pos[0]);

        issue(0, 1'b1, 0, 5, 0);
        repeat (3) @(negedge clock);

        issue(0, 1'b1, 5, 10, 7);
        repeat (6) @(negedge clock);
        abort = 1'b1;
        cmd_axis = 1'b1;
        jog_en[1] = 1'b1;
        #1;
        check("abort_cmd_ready", cmd_ready, 0);
        @(negedge clock);
        abort = 1'b0;
        jog_en[1] = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_step_out", step_out[0], 0);
        check("abort_pos_ax0", pos_of(0), model_pos[0]);
        check("abort_dir_hold", dir_out[0], 1);
        repeat (20) @(negedge clock);

        // Reset in the middle of a move
        issue(1, 1'b1, 4, 10, 0);
        repeat (8) @(negedge clock);
        width_en = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            exp_rise[i].delete();
            exp_done[i].delete();
        end
        model_pos = '{0, 0};
        free_at   = '{0, 0};
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_position", position, 0);
        check("midrst_step_out", step_out, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_cmd_ready", cmd_ready, 1);
        width_en = 1'b1;

        // Jog axis 0; jog_en drops while a pulse is high, jog_dir flips mid-jog
        @(negedge clock);
        e_entry = cyc + 1;
        jog_dir[0] = 1'b1;
        jog_en[0]  = 1'b1;
        x = jog_model(0, 1'b1, e_entry, e_entry + 17);
        repeat (8) @(negedge clock);
        jog_dir[0] = 1'b0;
        while (cyc < e_entry + 16) @(negedge clock);
        jog_en[0] = 1'b0;
        while (cyc < x - 1) @(negedge clock);
        check("jog_busy_before_exit", busy[0], 1);
        check("jog_dir_hold", dir_out[0], 1);
        @(negedge clock);
        check("jog_busy_after_exit", busy[0], 0);
        check("jog_pos_ax0", pos_of(0), model_pos[0]);
        repeat (5) @(negedge clock);

        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 2) == 0)
                issue(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 4)), int'($urandom_range(0, 12)), 0);
            else
                @(negedge clock);
        end

        repeat (80) @(negedge clock);
        for (int i = 0; i < N; i++) begin
            check($sformatf("final_pos_ax%0d", i), pos_of(i), model_pos[i]);
            check($sformatf("rise_left_ax%0d", i), exp_rise[i].size(), 0);
            check($sformatf("done_left_ax%0d", i), exp_done[i].size(), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
